// File: rtl/modred_pipe_pkg.sv
// Shared sizing helpers for the pipelined word-level Montgomery reducer.
// Stage widths are the proven bounds of the partially reduced value after k word steps.
package modred_pkg;

  localparam int QW_DEF   = 32;
  localparam int W_DEF    = 13;
  localparam int TAGW_DEF = 8;

  function automatic int num_stages(input int qw, input int w);
    return (qw + w - 1) / w;
  endfunction

  // X_k < 2^(2*qw - k*w) + q, so it fits in the larger of these two widths
  function automatic int stage_width(input int qw, input int w, input int k);
    int a;
    int b;
    a = 2 * qw - k * w + 1;
    b = qw + 2;
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/modred_pipe_if.sv
// Operand/result handshake bundle for modred_pipe.
// master drives operands and consumes results; slave is the reducer.
interface modred_pipe_if #(
  parameter int QW   = 32,
  parameter int TAGW = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2*QW-1:0]   d;
  logic [QW-1:0]     q;
  logic [TAGW-1:0]   tag;
  logic              out_valid;
  logic              out_ready;
  logic [QW-1:0]     c;
  logic [TAGW-1:0]   out_tag;

  modport master (
    output in_valid, d, q, tag, out_ready,
    input  in_ready, out_valid, c, out_tag
  );

  modport slave (
    input  in_valid, d, q, tag, out_ready,
    output in_ready, out_valid, c, out_tag
  );
endinterface

// File: rtl/modred_word_stage.sv
// One registered Montgomery word step: X' = X[top:W] + m*qh + (L != 0), m = -L mod 2^W.
// The modulus high part, tag and valid bit travel alongside the data.
module modred_word_stage #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 52,
  parameter int QHW   = 19,
  parameter int TAGW  = 8,
  parameter int W     = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv_i,
  input  logic             vld_i,
  input  logic [QHW-1:0]   qh_i,
  input  logic [TAGW-1:0]  tag_i,
  input  logic [IN_W-1:0]  x_i,
  output logic             vld_o,
  output logic [QHW-1:0]   qh_o,
  output logic [TAGW-1:0]  tag_o,
  output logic [OUT_W-1:0] x_o
);

  localparam int HI_W  = IN_W - W;
  localparam int PW    = QHW + W;
  localparam int A_W   = ((HI_W > PW) ? HI_W : PW) + 1;
  localparam int SUM_W = (A_W > OUT_W) ? A_W : OUT_W;

  typedef struct packed {
    logic             valid;
    logic [QHW-1:0]   qh;
    logic [TAGW-1:0]  tag;
    logic [OUT_W-1:0] x;
  } slot_t;

  slot_t          slot_q;
  slot_t          slot_d;
  logic [W-1:0]   lo;
  logic [W-1:0]   m;
  logic [PW-1:0]  prod;
  logic [SUM_W-1:0] sum;

  always_comb begin
    lo   = x_i[W-1:0];
    m    = -lo;
    prod = PW'(m) * PW'(qh_i);
    // the low word of X + m*q is zero; its carry out is exactly (L != 0)
    sum  = SUM_W'(x_i[IN_W-1:W]) + SUM_W'(prod) + SUM_W'(|lo);
    slot_d       = '0;
    slot_d.valid = vld_i;
    slot_d.qh    = qh_i;
    slot_d.tag   = tag_i;
    slot_d.x     = sum[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else if (adv_i) begin
      slot_q <= slot_d;
    end
  end

  assign vld_o = slot_q.valid;
  assign qh_o  = slot_q.qh;
  assign tag_o = slot_q.tag;
  assign x_o   = slot_q.x;

endmodule

// File: rtl/modred_pipe.sv
// Pipelined Montgomery reduction c = d * 2^(-W*S) mod q with per-operation modulus,
// sideband tag and a single global stall driven by the output register.
module modred_pipe
  import modred_pkg::*;
#(
  parameter int QW   = QW_DEF,
  parameter int W    = W_DEF,
  parameter int TAGW = TAGW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  modred_pipe_if.slave  bus
);

  localparam int S    = num_stages(QW, W);
  localparam int QHW  = QW - W;
  localparam int XMAX = 2 * QW;
  localparam int XW   = stage_width(QW, W, S);
  localparam int XW1  = XW + 1;

  logic              vld_chain [0:S];
  logic [QHW-1:0]    qh_chain  [0:S];
  logic [TAGW-1:0]   tag_chain [0:S];
  logic [XMAX-1:0]   x_chain   [0:S];

  logic              adv;
  logic              out_valid_q;
  logic [QW-1:0]     c_q;
  logic [QW-1:0]     c_d;
  logic [TAGW-1:0]   out_tag_q;
  logic [XW1-1:0]    x_fin;
  logic [XW1-1:0]    q_ext;
  logic [XW1-1:0]    t;

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  assign vld_chain[0] = bus.in_valid;
  assign qh_chain[0]  = bus.q[QW-1:W];
  assign tag_chain[0] = bus.tag;
  assign x_chain[0]   = bus.d;

  for (genvar k = 1; k <= S; k++) begin : g_stage
    localparam int IN_W  = (k == 1) ? XMAX : stage_width(QW, W, k - 1);
    localparam int OUT_W = stage_width(QW, W, k);

    logic [OUT_W-1:0] x_out;

    modred_word_stage #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .QHW   (QHW),
      .TAGW  (TAGW),
      .W     (W)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .adv_i (adv),
      .vld_i (vld_chain[k-1]),
      .qh_i  (qh_chain[k-1]),
      .tag_i (tag_chain[k-1]),
      .x_i   (x_chain[k-1][IN_W-1:0]),
      .vld_o (vld_chain[k]),
      .qh_o  (qh_chain[k]),
      .tag_o (tag_chain[k]),
      .x_o   (x_out)
    );

    assign x_chain[k] = XMAX'(x_out);
  end

  // X_S < 2q for legal inputs, so one conditional subtraction lands in [0, q)
  always_comb begin
    x_fin = XW1'(x_chain[S][XW-1:0]);
    q_ext = XW1'({qh_chain[S], {{(W-1){1'b0}}, 1'b1}});
    t     = x_fin - q_ext;
    c_d   = t[XW] ? x_fin[QW-1:0] : t[QW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      c_q         <= '0;
      out_tag_q   <= '0;
    end else if (adv) begin
      out_valid_q <= vld_chain[S];
      c_q         <= c_d;
      out_tag_q   <= tag_chain[S];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_modred_pipe.sv
// Self-checking bench for modred_pipe: vector table plus hand sequences, scoreboarded results
// against a bit-serial Montgomery model.
module tb_modred_pipe;

  localparam int QW   = 32;
  localparam int W    = 13;
  localparam int TAGW = 8;
  localparam logic [31:0] Q1 = 32'hFFFF_E001;
  localparam logic [31:0] Q2 = 32'h0000_6001;
  localparam logic [31:0] Q3 = 32'h7FFF_E001;
  localparam logic [63:0] R  = 64'd1 << 39;

  typedef struct {
    logic [63:0] d;
    logic [31:0] q;
    logic [7:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] c;
    logic [7:0]  tag;
    int          acc_cyc;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  modred_pipe_if #(.QW(QW), .TAGW(TAGW)) bus ();

  modred_pipe #(.QW(QW), .W(W), .TAGW(TAGW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_pop = 0;
  int          last_lat = 0;
  int          last_pop_cyc = 0;
  int          prev_pop_cyc = 0;
  logic [31:0] cur_exp = '0;
  logic [7:0]  cur_tag = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_c = '0;
  logic [7:0]  prev_tag = '0;
  sb_t         sb[$];
  vec_t        vecs[10];

  // independent model: reduce mod q, then halve mod q 39 times
  function automatic logic [31:0] mont_ref(input logic [63:0] d, input logic [31:0] q);
    logic [63:0] x;
    x = d % {32'd0, q};
    for (int i = 0; i < 39; i++)
      x = x[0] ? ((x + {32'd0, q}) >> 1) : (x >> 1);
    return x[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_rule", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
      if (prev_stall && bus.out_valid) begin
        chk("c_hold", 64'(bus.c), 64'(prev_c));
        chk("tag_hold", 64'(bus.out_tag), 64'(prev_tag));
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back('{c: cur_exp, tag: cur_tag, acc_cyc: cyc});
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got tag %0h c %0h expected no output", bus.out_tag, bus.c);
        end else begin
          e = sb.pop_front();
          chk("result_c", 64'(bus.c), 64'(e.c));
          chk("result_tag", 64'(bus.out_tag), 64'(e.tag));
          last_lat     = cyc - e.acc_cyc;
          prev_pop_cyc = last_pop_cyc;
          last_pop_cyc = cyc;
          n_pop++;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_c     = bus.c;
      prev_tag   = bus.out_tag;
    end
  end

  task automatic send(input logic [63:0] d, input logic [31:0] q, input logic [7:0] tag,
                      input logic [31:0] exp);
    int   n;
    logic acc;
    n = 0;
    bus.d = d;
    bus.q = q;
    bus.tag = tag;
    cur_exp = exp;
    cur_tag = tag;
    bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed %0b, required 1 within 200 cycles", bus.in_ready);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d0;
    logic [63:0] dbig;
    logic [63:0] d;
    logic [31:0] q;
    int          p0;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.d = '0;
    bus.q = '0;
    bus.tag = '0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_c", 64'(bus.c), 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // d0 = -R mod q, so d0 * R^-1 = q - 1 (largest result, subtract boundary)
    d0   = {32'd0, Q1} - (R % {32'd0, Q1});
    dbig = d0 + ((64'hFFFF_FFFF_FFFF_FFFF - d0) / {32'd0, Q1}) * {32'd0, Q1};
    vecs[0] = '{d: 64'd0,        q: Q1, tag: 8'hA5, exp: 32'd0};
    vecs[1] = '{d: R,            q: Q1, tag: 8'h01, exp: 32'd1};
    vecs[2] = '{d: {32'd0, Q1},  q: Q1, tag: 8'h02, exp: 32'd0};
    vecs[3] = '{d: d0,           q: Q1, tag: 8'h03, exp: 32'hFFFF_E000};
    vecs[4] = '{d: dbig,         q: Q1, tag: 8'h04, exp: 32'hFFFF_E000};
    vecs[5] = '{d: R,            q: Q2, tag: 8'h05, exp: 32'd1};
    vecs[6] = '{d: R * 64'd7,    q: Q3, tag: 8'h06, exp: 32'd7};
    vecs[7] = '{d: 64'd1,        q: Q1, tag: 8'h07, exp: mont_ref(64'd1, Q1)};
    vecs[8] = '{d: 64'hFFFF_FFFF_FFFF_FFFF, q: Q1, tag: 8'h08,
                exp: mont_ref(64'hFFFF_FFFF_FFFF_FFFF, Q1)};
    vecs[9] = '{d: 64'h0123_4567_89AB_CDEF, q: Q3, tag: 8'h09,
                exp: mont_ref(64'h0123_4567_89AB_CDEF, Q3)};

    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // first vector alone to pin latency
    send(vecs[0].d, vecs[0].q, vecs[0].tag, vecs[0].exp);
    drain();
    chk("latency_zero", 64'(last_lat), 64'd4);

    for (int i = 1; i < 10; i++)
      send(vecs[i].d, vecs[i].q, vecs[i].tag, vecs[i].exp);
    drain();

    for (int i = 0; i < 16; i++) begin
      case (i % 3)
        0: q = Q1;
        1: q = Q2;
        default: q = Q3;
      endcase
      d = {$urandom(), $urandom()};
      if (q == Q2) d = d >> 11;
      send(d, q, 8'(8'h20 + i), mont_ref(d, q));
    end
    drain();

    // per-op modulus, back to back, results on consecutive cycles
    send(R, Q1, 8'h40, 32'd1);
    send(R, Q2, 8'h41, 32'd1);
    drain();
    chk("no_bubble", 64'(last_pop_cyc - prev_pop_cyc), 64'd1);
    chk("latency_modsw", 64'(last_lat), 64'd4);

    // backpressure: out_ready low on cycles 3..6 of the stream
    p0 = n_pop;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          d = {$urandom(), $urandom()};
          send(d, Q1, 8'(i), mont_ref(d, Q1));
        end
        bus.in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 64'(n_pop - p0), 64'd8);

    // reset with three operations still in the stage registers
    for (int i = 0; i < 6; i++)
      send(R * 64'(i + 2), Q1, 8'(8'h60 + i), 32'(i + 2));
    bus.in_valid = 1'b0;
    chk("ov_before_rst", 64'(bus.out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_c", 64'(bus.c), 64'd0);
    chk("async_rst_tag", 64'(bus.out_tag), 64'd0);
    chk("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    p0 = n_pop;
    send(R * 64'd5, Q1, 8'h77, 32'd5);
    drain();
    chk("post_rst_count", 64'(n_pop - p0), 64'd1);
    chk("post_rst_latency", 64'(last_lat), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
